branch_target_predictor: RTL

- Parametrised direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Sits beside the IF-stage PC adder and predicts next PC at fetch.
- Is trained from the ID-stage branch comparator, which still resolves branches.
- Flags mispredicts so the pipeline flushes IF/ID, and keeps saturating lookup/mispredict statistics.

---
 rtl/branch_target_predictor_pkg.sv | 28 ++
 rtl/branch_target_predictor_sat_counter.sv | 35 +++
 rtl/branch_target_predictor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared sizing helpers and constants for the branch target predictor.
// Combinational constant functions only, no state.
// No flow control; consumed at elaboration time.
package branch_target_predictor_pkg;

    // Sequential fetch advances one 32-bit instruction word
    localparam int PC_INC = 4;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // pc[1:0] is dropped and the index consumes the next IDX_W bits
    function automatic int tag_width(input int pc_w, input int entries);
        return pc_w - $clog2(entries) - 2;
    endfunction

    // Weakly-not-taken: the counter value just below the taken threshold
    function automatic int wnt_val(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    // Weakly-taken: the lowest counter value with the MSB set
    function automatic int wt_val(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load and async reset value.
// Value updates one cycle after en/init; output is the registered value.
// No backpressure; inc and dec together hold the value.
module sat_counter #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    input  logic         init,
    input  logic [W-1:0] init_val,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_VAL = '1;

    // Load takes priority over counting; counting sticks at either end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RST_VAL;
        end else if (init) begin
            value <= init_val;
        end else if (en) begin
            if (inc && !dec && value != MAX_VAL) begin
                value <= value + W'(1);
            end else if (dec && !inc && value != '0) begin
                value <= value - W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counters, trained from ID.
// Lookup and mispredict are zero-latency; table/stats update at the next edge.
// No backpressure; lookup_en only gates the lookup statistic.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc_if,
    input  logic              lookup_en,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_next_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(PC_W, ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(wnt_val(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(wt_val(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    entry_t            tbl      [ENTRIES];
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    // Fetch-side lookup straight from the registered table
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    entry_t           if_ent;

    assign if_idx       = pc_if[IDX_W+1:2];
    assign if_tag       = pc_if[PC_W-1:IDX_W+2];
    assign if_ent       = tbl[if_idx];
    assign pred_hit     = if_ent.valid && (if_ent.tag == if_tag);
    assign pred_taken   = pred_hit && if_ent.ctr[CTR_W-1];
    assign pred_next_pc = pred_taken ? if_ent.target : pc_if + PC_W'(PC_INC);

    // ID-side resolution: classify the update against the current entry
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_ent;
    logic             upd_hit;
    logic             actual_taken;
    logic             do_train;
    logic             do_alloc;
    logic             do_inval;

    assign upd_idx      = upd_pc[IDX_W+1:2];
    assign upd_tag      = upd_pc[PC_W-1:IDX_W+2];
    assign upd_ent      = tbl[upd_idx];
    assign upd_hit      = upd_ent.valid && (upd_ent.tag == upd_tag);
    assign actual_taken = upd_is_branch && upd_taken;
    assign do_train     = upd_valid && upd_is_branch && upd_hit;
    assign do_alloc     = upd_valid && actual_taken && !upd_hit;
    // A non-branch hitting means the entry aliases a stale branch; drop it
    assign do_inval     = upd_valid && !upd_is_branch && upd_hit;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != actual_taken) ||
                         (actual_taken && (upd_pred_target != upd_target)));

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic sel;
        assign sel = (upd_idx == IDX_W'(i));

        sat_counter #(
            .W       (CTR_W),
            .RST_VAL (CTR_WNT)
        ) u_ctr (
            .clk      (clk),
            .rst      (reset),
            .en       (sel && do_train),
            .inc      (upd_taken),
            .dec      (!upd_taken),
            .init     (sel && do_alloc),
            .init_val (CTR_WT),
            .value    (ctr_q[i])
        );

        // Entry valid/tag/target: allocate on taken miss, retarget on taken hit, drop on alias
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end else if (sel) begin
                if (do_alloc) begin
                    valid_q[i]  <= 1'b1;
                    tag_q[i]    <= upd_tag;
                    target_q[i] <= upd_target;
                end else if (do_train && upd_taken) begin
                    target_q[i] <= upd_target;
                end else if (do_inval) begin
                    valid_q[i]  <= 1'b0;
                end
            end
        end

        assign tbl[i] = '{valid: valid_q[i], tag: tag_q[i], target: target_q[i], ctr: ctr_q[i]};
    end

    sat_counter #(
        .W       (STAT_W),
        .RST_VAL ('0)
    ) u_stat_lookups (
        .clk      (clk),
        .rst      (reset),
        .en       (lookup_en),
        .inc      (1'b1),
        .dec      (1'b0),
        .init     (1'b0),
        .init_val ('0),
        .value    (stat_lookups)
    );

    sat_counter #(
        .W       (STAT_W),
        .RST_VAL ('0)
    ) u_stat_mispredicts (
        .clk      (clk),
        .rst      (reset),
        .en       (mispredict),
        .inc      (1'b1),
        .dec      (1'b0),
        .init     (1'b0),
        .init_val ('0),
        .value    (stat_mispredicts)
    );

endmodule
